counter_updown_cfg: RTL and testbench
=====================================

# counter_updown_cfg

Parametrised up/down counter with synchronous load, programmable modulus (0..max_val), variable step, and selectable wrap or saturate mode. It reports terminal-count events and keeps sticky overflow and underflow flags. It is the general-purpose successor to the fixed 8-bit up/down/load counter, for timers, address sequencers and event counters across the design.

## Interface
- WIDTH, 8, counter, data, step and max_val width (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  count enable; 0 = hold
- load  in  1  synchronous load of data
- data  in  WIDTH  load value
- up  in  1  direction: 1 = up, 0 = down
- step  in  WIDTH  increment/decrement amount; 0 = hold
- max_val  in  WIDTH  upper bound; legal count range 0..max_val
- sat  in  1  1 = saturate at bounds, 0 = wrap modulo max_val+1
- clr_flags  in  1  synchronous clear of ovf/unf
- count  out  WIDTH  registered count
- tc  out  1  registered one-cycle pulse on each overflow/underflow event
- ovf  out  1  sticky overflow flag
- unf  out  1  sticky underflow flag
- at_max  out  1  combinational, count == max_val
- at_zero  out  1  combinational, count == 0

## Operation
- Priority per edge: rst=0 > load > en > hold.
- Load: count <= min(data, max_val). No flag change, tc=0.
- Effective step s = min(step, max_val). This guarantees that one correction term suffices.
- Arithmetic is done in WIDTH+1 bits. M = max_val+1 is a WIDTH+1-bit quantity.
- Out-of-range guard: if en, no load, and count > max_val (max_val was lowered), then count <= max_val. No flag, tc=0. This takes precedence over counting.
- Up, sum = count + s:
  - sum ≤ max_val: count <= sum.
  - sum > max_val, sat=0: count <= sum − M. Overflow event.
  - sum > max_val, sat=1: count <= max_val. Overflow event. This also applies when count is already max_val and s > 0.
- Down:
  - s ≤ count: count <= count − s.
  - s > count, sat=0: count <= count + M − s. Underflow event.
  - s > count, sat=1: count <= 0. Underflow event.
- Event effects:
  - tc = 1 for exactly the next cycle.
  - ovf (up) or unf (down) set.
  - Landing exactly on 0 or max_val is not an event.
- max_val = 0: count is always 0. Any enabled op with step > 0 gives s = 0, so count holds and no event occurs.
- clr_flags clears ovf and unf. If an event occurs in the same cycle, set wins for the affected flag; the other flag still clears.
- en=0 or s=0, without load: count holds, tc=0.

## Timing
- Reset (rst=0 at edge): count=0, tc=0, ovf=0, unf=0. Takes effect on that edge regardless of load/en.
- Reset mid-count discards any in-progress event. tc is 0 in the cycle after reset.
- All updates have 1-cycle latency: inputs sampled at edge N, outputs valid after edge N.
- tc is high for one cycle per event. Back-to-back events (e.g. repeated saturation clips) hold tc high continuously.
- at_max and at_zero follow count and max_val combinationally, with no extra latency.

## Test plan
- Reset: en=1, up=1, step=1, count=37, rst=0 for one edge → count=0, tc=0, ovf=0, unf=0. Then rst=1 → count=1 after the next edge.
- Wrap up: max_val=9, step=1, up=1, sat=0, starting from 0, 10 edges → 1…9, 0. tc high only after the 9→0 edge. ovf=1 from then on. at_max=1 while count=9.
- Saturate down: load 5; step=2, up=0, sat=1 → 3, 1, 0, 0. tc high after the 1→0 and 0→0 edges. unf=1, ovf=0.
- Wrap down and step clamp:
  - max_val=9, count=1, step=3, down, sat=0 → count=8, unf=1.
  - max_val=9, count=5, step=200, up, sat=0 → s=9, count=4, ovf=1.
- Load priority and clamp:
  - max_val=20, load=1, en=1, data=50 → count=20.
  - data=7 → count=7.
  - max_val lowered to 3 with en=1 → count=3, tc=0.
- Flag clear: with ovf=1, assert clr_flags together with an up-overflow event → ovf stays 1. Assert clr_flags alone → ovf=0 and unf=0 next cycle.

Source files
------------

// File: rtl/counter_updown_cfg.sv
// Up/down counter with load, programmable modulus 0..max_val, variable step, wrap or saturate.
// Latency: one cycle from sampled inputs to count/tc/ovf/unf; at_max/at_zero are combinational.
// Backpressure: none; en=0 or an effective step of 0 holds the count.
module counter_updown_cfg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] max_val_i,
  input  logic             sat_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic             at_max_o,
  output logic             at_zero_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] s_eff;      // step clamped to max_val so one wrap correction is enough
  logic [WIDTH-1:0] load_val;   // load data clamped into range
  logic [WIDTH:0]   mod_ext;    // max_val + 1, needs the extra bit when max_val is all ones
  logic [WIDTH:0]   max_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   up_wrap;
  logic [WIDTH:0]   dn_wrap;
  logic             ovf_evt;
  logic             unf_evt;

  // Extended-width operands shared by both directions.
  always_comb begin
    s_eff    = (step_i > max_val_i) ? max_val_i : step_i;
    load_val = (data_i > max_val_i) ? max_val_i : data_i;
    max_ext  = {1'b0, max_val_i};
    mod_ext  = max_ext + {{WIDTH{1'b0}}, 1'b1};
    sum_ext  = {1'b0, count_q} + {1'b0, s_eff};
    up_wrap  = sum_ext - mod_ext;
    dn_wrap  = {1'b0, count_q} + mod_ext - {1'b0, s_eff};
  end

  // Next count and event detection: load > range guard > count > hold.
  always_comb begin
    count_d = count_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (load_i) begin
      count_d = load_val;
    end else if (en_i) begin
      if (count_q > max_val_i) begin
        // max_val was lowered under the current count; pull back into range quietly
        count_d = max_val_i;
      end else if (up_i) begin
        if (sum_ext > max_ext) begin
          ovf_evt = 1'b1;
          count_d = sat_i ? max_val_i : up_wrap[WIDTH-1:0];
        end else begin
          count_d = sum_ext[WIDTH-1:0];
        end
      end else begin
        if (s_eff <= count_q) begin
          count_d = count_q - s_eff;
        end else begin
          unf_evt = 1'b1;
          count_d = sat_i ? '0 : dn_wrap[WIDTH-1:0];
        end
      end
    end
  end

  // Flags: an event in this cycle beats a clear of the same flag.
  always_comb begin
    tc_d  = ovf_evt | unf_evt;
    ovf_d = ovf_evt | (ovf_q & ~clr_flags_i);
    unf_d = unf_evt | (unf_q & ~clr_flags_i);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o   = count_q;
  assign tc_o      = tc_q;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;
  assign at_max_o  = (count_q == max_val_i);
  assign at_zero_o = (count_q == '0);

endmodule

// File: tb/tb_counter_updown_cfg.sv
// Bench for counter_updown_cfg: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against an integer model of the counting rules.
module tb_counter_updown_cfg;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, load, up, sat, clr;
  logic [W-1:0] data, step, max_val;
  logic [W-1:0] count;
  logic         tc, ovf, unf, at_max, at_zero;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // model state
  int m_cnt = 0;
  int m_tc  = 0;
  int m_ovf = 0;
  int m_unf = 0;

  counter_updown_cfg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en_i(en), .load_i(load), .data_i(data), .up_i(up),
    .step_i(step), .max_val_i(max_val), .sat_i(sat), .clr_flags_i(clr),
    .count_o(count), .tc_o(tc), .ovf_o(ovf), .unf_o(unf),
    .at_max_o(at_max), .at_zero_o(at_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Integer model: the counting rules written as plain arithmetic on the sampled inputs.
  always @(posedge clk) begin : model
    int mx, s, c, nc, ev_o, ev_u;
    mx = int'(max_val);
    s  = (int'(step) < mx) ? int'(step) : mx;
    c  = m_cnt;
    nc = c;
    ev_o = 0;
    ev_u = 0;
    if (load) begin
      nc = (int'(data) < mx) ? int'(data) : mx;
    end else if (en) begin
      if (c > mx)               nc = mx;
      else if (up) begin
        if (c + s > mx) begin ev_o = 1; nc = sat ? mx : c + s - (mx + 1); end
        else nc = c + s;
      end else begin
        if (s > c) begin ev_u = 1; nc = sat ? 0 : c + (mx + 1) - s; end
        else nc = c - s;
      end
    end
    if (!rst) begin
      m_cnt <= 0; m_tc <= 0; m_ovf <= 0; m_unf <= 0;
    end else begin
      m_cnt <= nc;
      m_tc  <= ev_o | ev_u;
      m_ovf <= (ev_o != 0 || (m_ovf != 0 && !clr)) ? 1 : 0;
      m_unf <= (ev_u != 0 || (m_unf != 0 && !clr)) ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("count",   int'(count),   m_cnt);
      check("tc",      int'(tc),      m_tc);
      check("ovf",     int'(ovf),     m_ovf);
      check("unf",     int'(unf),     m_unf);
      check("at_max",  int'(at_max),  (m_cnt == int'(max_val)) ? 1 : 0);
      check("at_zero", int'(at_zero), (m_cnt == 0) ? 1 : 0);
    end
  end

  // Apply the current inputs at one edge; return shortly after it.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int v, input int mx);
    load = 1'b1; en = 1'b0; clr = 1'b0; data = W'(v); max_val = W'(mx);
    cyc();
    load = 1'b0;
  endtask

  task automatic clear_flags();
    load = 1'b0; en = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; up = 1'b1; sat = 1'b0; clr = 1'b0;
    data = '0; step = 8'd1; max_val = 8'd255;
    cyc(); cyc();
    cmp_on = 1'b1;
    rst = 1'b1;
    check("reset_count", int'(count), 0);
    check("reset_tc",    int'(tc),    0);

    // reset while counting
    do_load(37, 255);
    check("load37", int'(count), 37);
    en = 1'b1; up = 1'b1; step = 8'd1; rst = 1'b0;
    cyc();
    check("rst_count", int'(count), 0);
    check("rst_flags", int'({tc, ovf, unf}), 0);
    rst = 1'b1;
    cyc();
    check("post_rst", int'(count), 1);

    // wrap up modulo 10
    do_load(0, 9);
    en = 1'b1; up = 1'b1; step = 8'd1; sat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("wrap_up_cnt", int'(count), (i + 1) % 10);
      check("wrap_up_tc",  int'(tc),    (i == 9) ? 1 : 0);
      if (i == 8) check("wrap_up_atmax", int'(at_max), 1);
    end
    check("wrap_up_ovf", int'(ovf), 1);

    // saturate down from 5 by 2
    clear_flags();
    do_load(5, 9);
    en = 1'b1; up = 1'b0; step = 8'd2; sat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int exp_c[4] = '{3, 1, 0, 0};
      cyc();
      check("sat_dn_cnt", int'(count), exp_c[i]);
      check("sat_dn_tc",  int'(tc),    (i >= 2) ? 1 : 0);
    end
    check("sat_dn_flags", int'({ovf, unf}), 1);

    // wrap down and step clamp
    clear_flags();
    do_load(1, 9);
    en = 1'b1; up = 1'b0; step = 8'd3; sat = 1'b0;
    cyc();
    check("wrap_dn_cnt", int'(count), 8);
    check("wrap_dn_unf", int'(unf),   1);
    do_load(5, 9);
    en = 1'b1; up = 1'b1; step = 8'd200;
    cyc();
    check("clamp_cnt", int'(count), 4);
    check("clamp_ovf", int'(ovf),   1);

    // load priority and clamp, then lowered max_val
    load = 1'b1; en = 1'b1; data = 8'd50; max_val = 8'd20;
    cyc();
    check("load_clamp", int'(count), 20);
    data = 8'd7;
    cyc();
    check("load_7", int'(count), 7);
    load = 1'b0; max_val = 8'd3; up = 1'b1; step = 8'd1;
    cyc();
    check("guard_cnt", int'(count), 3);
    check("guard_tc",  int'(tc),    0);

    // clear with simultaneous overflow, then clear alone
    sat = 1'b1; clr = 1'b1;
    cyc();
    check("clr_evt_ovf", int'(ovf), 1);
    check("clr_evt_tc",  int'(tc),  1);
    en = 1'b0;
    cyc();
    check("clr_ovf", int'(ovf), 0);
    check("clr_unf", int'(unf), 0);
    clr = 1'b0;

    // max_val = 0 holds at zero
    do_load(0, 0);
    en = 1'b1; step = 8'd5; up = 1'b0;
    cyc();
    check("max0_cnt", int'(count), 0);
    check("max0_tc",  int'(tc),    0);

    // random traffic, model comparison only
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 99) != 0);
      load    = ($urandom_range(0, 15) == 0);
      en      = ($urandom_range(0, 7) != 0);
      up      = $urandom_range(0, 1) != 0;
      sat     = $urandom_range(0, 1) != 0;
      clr     = ($urandom_range(0, 15) == 0);
      data    = W'($urandom);
      step    = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0)
        max_val = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 12));
      cyc();
    end

    rst = 1'b1; en = 1'b0; load = 1'b0;
    cyc();
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
